uart_tx: RTL and testbench

Serial UART transmitter. It converts bytes from a valid/ready handshake into 8-bit, LSB-first frames on a single TX line, with a configurable bit period and stop-bit count. It is the transmit-direction counterpart of the UART receive path inside the design top, and it drives the board-level `tx_o` pin through the FPGA wrapper.

---
 rtl/uart_tx.sv | 169 ++++++++++++++++
 tb/tb_uart_tx.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// Serial UART transmitter: 8 data bits, LSB first, idle-high line,
// configurable bit period and 1 or 2 stop bits. A byte is taken from a
// valid/ready handshake and shifted out as one frame.
//
// Optional feature macro: UART_TX_PARITY_EN
//   defined   : an even-parity bit (XOR of the byte) follows data bit 7
//   undefined : no parity state or logic, frame is 8N1 / 8N2
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (>= 2)
//   STOP_BITS    : number of stop bits, 1 or 2
//
// Ports
//   clk_i      : master clock
//   rst_n_i    : asynchronous active-low reset
//   tx_data_i  : byte to send, sampled only on the handshake edge
//   tx_valid_i : a byte is offered
//   tx_ready_o : block can accept a byte (high only in IDLE)
//   tx_o       : registered serial line, idle high
//   tx_busy_o  : a frame is in progress
//   tx_done_o  : one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx #(
   parameter int CLKS_PER_BIT = 434,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic [7:0] tx_data_i,
   input  logic       tx_valid_i,
   output logic       tx_ready_o,
   output logic       tx_o,
   output logic       tx_busy_o,
   output logic       tx_done_o
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t          state;
   state_t          state_nx;
   logic [CW-1:0]   baud_cnt;
   logic [2:0]      bit_idx;
   logic            stop_cnt;
   logic [7:0]      data_q;
   logic            tx_q;
   logic            tx_nx;
   logic            done_q;
   logic            done_nx;
   logic            accept;
   logic            bit_end;
   logic            last_stop;

   assign accept    = tx_valid_i && (state == IDLE);
   assign bit_end   = (baud_cnt == CW'(CLKS_PER_BIT - 1));
   // A single stop counter bit covers both legal stop-bit counts.
   assign last_stop = (stop_cnt == 1'(STOP_BITS - 1));

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) state <= IDLE;
      else          state <= state_nx;
   end

   // ------------------------------------------------------------------
   // Next state and next line level. The line level is computed for the
   // state being entered so that tx_o changes on the same edge as the
   // state, giving zero latency from the transfer edge to the start bit.
   // ------------------------------------------------------------------
   always_comb begin
      state_nx = state;
      tx_nx    = tx_q;
      done_nx  = 1'b0;
      case (state)
         IDLE: begin
            tx_nx = 1'b1;
            if (accept) begin
               state_nx = START;
               tx_nx    = 1'b0;
            end
         end
         START: begin
            if (bit_end) begin
               state_nx = DATA;
               tx_nx    = data_q[0];
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                  state_nx = PARITY;
                  tx_nx    = ^data_q;
`else
                  state_nx = STOP;
                  tx_nx    = 1'b1;
`endif
               end else begin
                  tx_nx = data_q[bit_idx + 3'd1];
               end
            end
         end
`ifdef UART_TX_PARITY_EN
         PARITY: begin
            if (bit_end) begin
               state_nx = STOP;
               tx_nx    = 1'b1;
            end
         end
`endif
         STOP: begin
            tx_nx = 1'b1;
            if (bit_end && last_stop) begin
               state_nx = IDLE;
               done_nx  = 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            tx_nx    = 1'b1;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath: baud counter, bit index, stop counter, byte latch, outputs
   // ------------------------------------------------------------------
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         baud_cnt <= '0;
         bit_idx  <= '0;
         stop_cnt <= 1'b0;
         data_q   <= '0;
         tx_q     <= 1'b1;
         done_q   <= 1'b0;
      end else begin
         // Held at zero in IDLE so the start bit gets a full period.
         if (state == IDLE || bit_end) baud_cnt <= '0;
         else                          baud_cnt <= baud_cnt + CW'(1);

         // Index wraps 7 -> 0 naturally as DATA is left.
         if (state != DATA)  bit_idx <= '0;
         else if (bit_end)   bit_idx <= bit_idx + 3'd1;

         if (state != STOP)  stop_cnt <= 1'b0;
         else if (bit_end)   stop_cnt <= last_stop ? 1'b0 : 1'b1;

         if (accept) data_q <= tx_data_i;

         tx_q   <= tx_nx;
         done_q <= done_nx;
      end
   end

   assign tx_ready_o = (state == IDLE);
   assign tx_busy_o  = (state != IDLE);
   assign tx_o       = tx_q;
   assign tx_done_o  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// ---------------------------------------------------------------------------
// tb_uart_tx
// Two transmitters (1 and 2 stop bits) with CLKS_PER_BIT = 4. The stimulus
// branch pushes every accepted byte into a per-instance queue; the monitor
// branch watches each line, turns a popped byte into the expected per-bit
// level list and compares every cycle of the frame plus the done pulse.
// ---------------------------------------------------------------------------
module tb_uart_tx;

   localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
   localparam int P = 1;
`else
   localparam int P = 0;
`endif

   logic            clk = 1'b0;
   logic            rst_n;
   logic [1:0]      valid;
   logic [1:0][7:0] data;
   logic [1:0]      tx, ready, busy, done;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      uart_tx #(.CLKS_PER_BIT(CPB), .STOP_BITS(g + 1)) u_dut (
         .clk_i      (clk),
         .rst_n_i    (rst_n),
         .tx_data_i  (data[g]),
         .tx_valid_i (valid[g]),
         .tx_ready_o (ready[g]),
         .tx_o       (tx[g]),
         .tx_busy_o  (busy[g]),
         .tx_done_o  (done[g])
      );
   end

   int          total = 0;
   int          bad   = 0;
   logic [7:0]  q0[$];
   logic [7:0]  q1[$];
   bit          in_frame [2];
   bit          b2b      [2];
   int          cyc      [2];
   int          nb       [2];
   int          last_done[2];
   int          frames   [2];
   logic [11:0] expv     [2];
   int          ncyc = 0;

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   // Offer a byte after a falling edge, wait for the transfer edge, record it.
   task automatic send(input int i, input logic [7:0] d, input bit hold);
      bit ok;
      ok = 0;
      @(negedge clk);
      valid[i] = 1'b1;
      data[i]  = d;
      for (int k = 0; k < 400; k++) begin
         if (ready[i]) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         chk($sformatf("u%0d_accept_timeout", i), 0, 1);
         valid[i] = 1'b0;
      end else begin
         @(posedge clk);
         if (i == 0) q0.push_back(d); else q1.push_back(d);
         #1;
         if (!hold) valid[i] = 1'b0;
      end
   endtask

   task automatic wait_idle();
      bit ok;
      ok = 0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk); #1;
         if (busy == 2'b00 && !in_frame[0] && !in_frame[1] &&
             q0.size() == 0 && q1.size() == 0) begin ok = 1; break; end
      end
      if (!ok) chk("idle_timeout", 0, 1);
      repeat (2) @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      valid = '0;
      data  = '0;
      for (int i = 0; i < 2; i++) begin
         in_frame[i] = 0; b2b[i] = 0; cyc[i] = 0; nb[i] = 0;
         last_done[i] = 0; frames[i] = 0; expv[i] = '1;
      end
      #12;
      chk("rst_tx",    int'(tx),    3);
      chk("rst_ready", int'(ready), 3);
      chk("rst_busy",  int'(busy),  0);
      chk("rst_done",  int'(done),  0);
      @(negedge clk);
      rst_n = 1'b1;

      fork
         // -------------------- monitor --------------------
         forever begin
            @(negedge clk);
            ncyc++;
            for (int i = 0; i < 2; i++) begin
               if (!rst_n) begin
                  in_frame[i] = 0;
               end else if (in_frame[i]) begin
                  cyc[i]++;
                  if (cyc[i] < nb[i] * CPB) begin
                     chk($sformatf("u%0d_bit%0d", i, cyc[i] / CPB),
                         int'(tx[i]), int'(expv[i][cyc[i] / CPB]));
                     chk($sformatf("u%0d_busy_ready", i), int'({busy[i], ready[i]}), 2);
                     chk($sformatf("u%0d_early_done", i), int'(done[i]), 0);
                  end else begin
                     chk($sformatf("u%0d_done_pulse", i), int'(done[i]), 1);
                     chk($sformatf("u%0d_end_line", i), int'(tx[i]), 1);
                     chk($sformatf("u%0d_end_ready", i), int'({busy[i], ready[i]}), 1);
                     in_frame[i]  = 0;
                     last_done[i] = ncyc;
                     frames[i]++;
                  end
               end else if (tx[i] == 1'b0) begin
                  logic [7:0] d;
                  d = 8'h00;
                  if (i == 0 && q0.size() > 0)      d = q0.pop_front();
                  else if (i == 1 && q1.size() > 0) d = q1.pop_front();
                  else chk($sformatf("u%0d_unexpected_start", i), 1, 0);
                  // Expected line levels, one entry per bit period.
                  expv[i]    = '1;
                  expv[i][0] = 1'b0;
                  for (int k = 0; k < 8; k++) expv[i][1 + k] = d[k];
                  if (P == 1) expv[i][9] = ^d;
                  nb[i] = 1 + 8 + P + (i + 1);
                  if (b2b[i]) begin
                     chk($sformatf("u%0d_b2b_gap", i), ncyc - last_done[i], 1);
                     b2b[i] = 0;
                  end
                  chk($sformatf("u%0d_start_busy", i), int'({busy[i], ready[i]}), 2);
                  chk($sformatf("u%0d_start_done", i), int'(done[i]), 0);
                  cyc[i]      = 0;
                  in_frame[i] = 1;
               end else begin
                  chk($sformatf("u%0d_idle_state", i),
                      int'({tx[i], busy[i], ready[i], done[i]}), 4'b1010);
               end
            end
         end

         // -------------------- stimulus --------------------
         begin
            repeat (20) @(negedge clk);

            send(0, 8'h55, 0);
            wait_idle();
            send(0, 8'h01, 0);
            wait_idle();
            send(0, 8'h03, 0);
            wait_idle();

            // Held valid, data changes during the first frame.
            send(1, 8'hA5, 1);
            data[1] = 8'h3C;
            @(negedge clk); #1;
            b2b[1] = 1;
            send(1, 8'h3C, 0);
            @(negedge clk);
            data[1] = 8'hFF;
            wait_idle();

            // Reset in the middle of data bit 3.
            send(0, 8'hF0, 0);
            repeat (17) @(posedge clk);
            #2 rst_n = 1'b0;
            #1;
            chk("midrst_tx",    int'(tx[0]),    1);
            chk("midrst_ready", int'(ready[0]), 1);
            chk("midrst_busy",  int'(busy[0]),  0);
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            #1;
            chk("postrst_ready", int'(ready[0]), 1);
            chk("postrst_done",  int'(done[0]),  0);
            send(0, 8'h96, 0);
            wait_idle();

            // Random bytes with random spacing on both instances.
            for (int n = 0; n < 16; n++) begin
               int i;
               i = n % 2;
               send(i, 8'($urandom_range(0, 255)), 0);
               repeat ($urandom_range(0, 6)) @(negedge clk);
            end
            wait_idle();

            chk("u0_frames", frames[0], 4 + 8);
            chk("u1_frames", frames[1], 2 + 8);
            chk("q0_left", q0.size(), 0);
            chk("q1_left", q1.size(), 0);
         end
      join_any

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
